// File: rtl/cpu_sequential.sv
// cpu_sequential: single-cycle RV64 subset core (add, sub, and, or, addi,
// ld, sd, beq). Every instruction fetches, executes and retires in one clk
// cycle, so CPI is 1. Any opcode outside the subset executes as a NOP.
//
// Ports:
//   clk   - rising-edge clock for the PC, register file and data memory
//   reset - asynchronous, active-low; clears the PC and all 32 registers.
//           Instruction and data memory contents are kept.
//
// Instruction memory is loaded and results are read through hierarchy:
//   imem.memory (256 x 32), dmem.memory (256 x 64), reg_file.registers (32 x 64)

module cpu_imem (
    input  logic        clk,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [31:0] load_data,
    input  logic [7:0]  addr,
    output logic [31:0] data
);
    logic [31:0] memory [0:255];

    // The load port is tied off in the core. Program images are placed
    // into memory[] through hierarchy.
    always_ff @(posedge clk) begin
        if (load_en) memory[load_addr] <= load_data;
    end

    assign data = memory[addr];
endmodule

module cpu_dmem (
    input  logic        clk,
    input  logic        write_en,
    input  logic [7:0]  addr,
    input  logic [63:0] write_data,
    output logic [63:0] read_data
);
    logic [63:0] memory [0:255];

    always_ff @(posedge clk) begin
        if (write_en) memory[addr] <= write_data;
    end

    assign read_data = memory[addr];
endmodule

module cpu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  read_addr1,
    input  logic [4:0]  read_addr2,
    input  logic        write_en,
    input  logic [4:0]  write_addr,
    input  logic [63:0] write_data,
    output logic [63:0] read_data1,
    output logic [63:0] read_data2
);
    logic [63:0] registers [0:31];

    // x0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (write_en && (write_addr != 5'd0)) begin
            registers[write_addr] <= write_data;
        end
    end

    // Reads return the pre-edge value, so a same-cycle write becomes
    // visible only in the following cycle.
    assign read_data1 = (read_addr1 == 5'd0) ? 64'd0 : registers[read_addr1];
    assign read_data2 = (read_addr2 == 5'd0) ? 64'd0 : registers[read_addr2];
endmodule

module cpu_sequential (
    input logic clk,
    input logic reset
);
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;

    logic [63:0] pc_current, pc_next;
    logic [31:0] instruction;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    alu_op_t     alu_op;
    logic [63:0] imm_i, imm_s, imm_b, imm;
    logic [63:0] reg_read_data1, reg_read_data2, alu_b, alu_result;
    logic [63:0] mem_read_data, reg_write_data;
    logic        zero;

    // Fetch and decode
    cpu_imem imem (
        .clk       (clk),
        .load_en   (1'b0),
        .load_addr (8'd0),
        .load_data (32'd0),
        .addr      (pc_current[9:2]),
        .data      (instruction)
    );

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    assign imm_i = {{52{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{51{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    // Only sd uses the S layout; addi and ld share the I layout.
    assign imm   = (opcode == OP_STORE) ? imm_s : imm_i;

    // Control decode. Anything unmatched leaves every control at 0 (NOP).
    always_comb begin
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        alu_op     = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            reg_write = 1'b1;
                        end else if (funct7 == 7'b0100000) begin
                            reg_write = 1'b1;
                            alu_op    = ALU_SUB;
                        end
                    end
                    3'b111: begin
                        reg_write = 1'b1;
                        alu_op    = ALU_AND;
                    end
                    3'b110: begin
                        reg_write = 1'b1;
                        alu_op    = ALU_OR;
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                if (funct3 == 3'b000) begin
                    alu_src   = 1'b1;
                    reg_write = 1'b1;
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'b011) begin
                    mem_read   = 1'b1;
                    mem_to_reg = 1'b1;
                    alu_src    = 1'b1;
                    reg_write  = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b011) begin
                    mem_write = 1'b1;
                    alu_src   = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000) begin
                    branch = 1'b1;
                    alu_op = ALU_SUB;
                end
            end
            default: ;
        endcase
    end

    // Register file
    cpu_regfile reg_file (
        .clk        (clk),
        .reset      (reset),
        .read_addr1 (rs1),
        .read_addr2 (rs2),
        .write_en   (reg_write),
        .write_addr (rd),
        .write_data (reg_write_data),
        .read_data1 (reg_read_data1),
        .read_data2 (reg_read_data2)
    );

    // Execute
    assign alu_b = alu_src ? imm : reg_read_data2;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = reg_read_data1 + alu_b;
            ALU_SUB: alu_result = reg_read_data1 - alu_b;
            ALU_AND: alu_result = reg_read_data1 & alu_b;
            ALU_OR:  alu_result = reg_read_data1 | alu_b;
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == 64'd0);

    // Memory. The store is gated by reset because the data memory has no
    // reset of its own; an instruction caught by reset must not write.
    cpu_dmem dmem (
        .clk        (clk),
        .write_en   (mem_write & reset),
        .addr       (alu_result[10:3]),
        .write_data (reg_read_data2),
        .read_data  (mem_read_data)
    );

    // Write-back and next PC
    assign reg_write_data = mem_to_reg ? mem_read_data : alu_result;
    assign pc_next        = (branch && zero) ? (pc_current + imm_b) : (pc_current + 64'd4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_current <= '0;
        else        pc_current <= pc_next;
    end
endmodule

// File: tb/tb_cpu_sequential.sv
// Directed bench for cpu_sequential: loads small programs into imem through
// hierarchy, steps a fixed number of cycles and checks architectural state.

module tb_cpu_sequential;
    logic clk;
    logic reset;

    int pass_count  = 0;
    int check_count = 0;

    cpu_sequential dut (
        .clk   (clk),
        .reset (reset)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Helpers
    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) dut.imem.memory[i] <= 32'h0;
        #1;
    endtask

    task automatic put(input int word_addr, input logic [31:0] instr);
        dut.imem.memory[word_addr] <= instr;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic load_loop_prog();
        clear_imem();
        put(0, 32'h00200093);  // addi x1,x0,2
        put(1, 32'h00700113);  // addi x2,x0,7
        put(2, 32'h00008863);  // beq  x1,x0,+16
        put(3, 32'h00110133);  // add  x2,x2,x1
        put(4, 32'hFFF08093);  // addi x1,x1,-1
        put(5, 32'hFE000AE3);  // beq  x0,x0,-12
    endtask

    task automatic check_loop_result(input string tag);
        check({tag, "_pc"}, dut.pc_current, 64'h18);
        check({tag, "_x1"}, dut.reg_file.registers[1], 64'd0);
        check({tag, "_x2"}, dut.reg_file.registers[2], 64'd10);
        check({tag, "_x0"}, dut.reg_file.registers[0], 64'd0);
        for (int k = 3; k < 32; k++)
            check($sformatf("%s_x%0d", tag, k), dut.reg_file.registers[k], 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        #2 reset = 1'b0;

        // Loop program; 11 instructions retire before reaching 0x18.
        load_loop_prog();
        #1;
        check("reset_pc", dut.pc_current, 64'd0);
        check("reset_x1", dut.reg_file.registers[1], 64'd0);
        release_reset();
        check("first_fetch", {32'd0, dut.instruction}, 64'h00200093);
        run(11);
        check_loop_result("loop");

        // Store / load round trip
        reset = 1'b0;
        clear_imem();
        put(0, 32'h02A00193);  // addi x3,x0,42
        put(1, 32'h00303423);  // sd   x3,8(x0)
        put(2, 32'h00803203);  // ld   x4,8(x0)
        release_reset();
        check("addi_mem_write", dut.mem_write, 1'b0);
        check("addi_mem_read", dut.mem_read, 1'b0);
        run(1);
        check("sd_mem_write", dut.mem_write, 1'b1);
        check("sd_mem_read", dut.mem_read, 1'b0);
        check("sd_alu_addr", dut.alu_result, 64'd8);
        run(1);
        check("ld_mem_write", dut.mem_write, 1'b0);
        check("ld_mem_read", dut.mem_read, 1'b1);
        check("ld_mem_to_reg", dut.mem_to_reg, 1'b1);
        check("dmem_1", dut.dmem.memory[1], 64'd42);
        check("ld_read_data", dut.mem_read_data, 64'd42);
        check("ld_x4_not_yet", dut.reg_file.registers[4], 64'd0);
        run(1);
        check("ld_x4", dut.reg_file.registers[4], 64'd42);
        check("nop_mem_read", dut.mem_read, 1'b0);
        check("nop_reg_write", dut.reg_write, 1'b0);
        reset = 1'b0;
        #1;
        check("dmem_kept_over_reset", dut.dmem.memory[1], 64'd42);
        check("x3_cleared", dut.reg_file.registers[3], 64'd0);

        // R-type ALU operations
        clear_imem();
        put(0, 32'h00C00093);  // addi x1,x0,12
        put(1, 32'h00A00113);  // addi x2,x0,10
        put(2, 32'h402081B3);  // sub  x3,x1,x2
        put(3, 32'h0020F233);  // and  x4,x1,x2
        put(4, 32'h0020E2B3);  // or   x5,x1,x2
        put(5, 32'h40110333);  // sub  x6,x2,x1
        put(6, 32'h0020C3B3);  // xor  x7,x1,x2 (unsupported funct3)
        release_reset();
        run(6);
        check("xor_reg_write", dut.reg_write, 1'b0);
        run(1);
        check("sub_x3", dut.reg_file.registers[3], 64'd2);
        check("and_x4", dut.reg_file.registers[4], 64'd8);
        check("or_x5", dut.reg_file.registers[5], 64'd14);
        check("sub_x6", dut.reg_file.registers[6], 64'hFFFF_FFFF_FFFF_FFFE);
        check("xor_x7", dut.reg_file.registers[7], 64'd0);
        check("rtype_pc", dut.pc_current, 64'h1C);

        // x0 protection
        reset = 1'b0;
        clear_imem();
        put(0, 32'h00300093);  // addi x1,x0,3
        put(1, 32'h00500013);  // addi x0,x0,5
        put(2, 32'h000000B3);  // add  x1,x0,x0
        release_reset();
        run(1);
        check("x1_preload", dut.reg_file.registers[1], 64'd3);
        run(1);
        check("x0_after_addi", dut.reg_file.registers[0], 64'd0);
        check("x0_read", dut.reg_read_data2, 64'd0);
        run(1);
        check("x1_from_x0", dut.reg_file.registers[1], 64'd0);

        // beq not taken
        reset = 1'b0;
        clear_imem();
        put(0, 32'h00100093);  // addi x1,x0,1
        put(1, 32'h00008463);  // beq  x1,x0,+8
        put(2, 32'h00700113);  // addi x2,x0,7
        put(3, 32'h00900193);  // addi x3,x0,9
        release_reset();
        run(1);
        check("beq_nt_branch", dut.branch, 1'b1);
        check("beq_nt_zero", {63'd0, dut.alu_result == 64'd0}, 64'd0);
        run(1);
        check("beq_nt_pc", dut.pc_current, 64'h8);
        run(1);
        check("beq_nt_x2", dut.reg_file.registers[2], 64'd7);

        // Reset mid-run of the loop program
        reset = 1'b0;
        load_loop_prog();
        release_reset();
        run(3);
        check("mid_pc_before", dut.pc_current, 64'hC);
        check("mid_x1_before", dut.reg_file.registers[1], 64'd2);
        check("mid_x2_before", dut.reg_file.registers[2], 64'd7);
        reset = 1'b0;
        #1;
        check("mid_pc_async", dut.pc_current, 64'd0);
        check("mid_x1_async", dut.reg_file.registers[1], 64'd0);
        check("mid_x2_async", dut.reg_file.registers[2], 64'd0);
        run(1);
        check("mid_pc_held", dut.pc_current, 64'd0);
        check("mid_x1_held", dut.reg_file.registers[1], 64'd0);
        release_reset();
        run(11);
        check_loop_result("rerun");

        // Final report
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
